// File: rtl/mdu_pkg.sv
// Shared types for the MDU issue path: operation encodings, command word, helpers.
package mdu_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        READ_HI    = 3'd0,
        READ_LO    = 3'd1,
        WRITE_HI   = 3'd2,
        WRITE_LO   = 3'd3,
        START_SMUL = 3'd4,
        START_UMUL = 3'd5,
        START_SDIV = 3'd6,
        START_UDIV = 3'd7
    } mdu_operation_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PENDING  = 2'd1,
        DISPATCH = 2'd2
    } issue_state_t;

    function automatic logic is_start_op(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_read_op(input logic [2:0] op);
        return (op[2:1] == 2'b00);
    endfunction

endpackage

// File: rtl/mdu_cmd_fifo.sv
// In-order command queue of {op, operand1, operand2}; DEPTH must be a power of two >= 2.
// Push is ignored when full, pop is ignored when empty; full/count reflect the pre-update state.
module mdu_cmd_fifo
    import mdu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int OP_W  = 3,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [OP_W-1:0]  push_op,
    input  word_t            push_operand1,
    input  word_t            push_operand2,
    input  logic             pop,
    output logic [OP_W-1:0]  head_op,
    output word_t            head_operand1,
    output word_t            head_operand2,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [OP_W-1:0]  op_mem [DEPTH];
    word_t            a_mem  [DEPTH];
    word_t            b_mem  [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign head_op       = op_mem[head];
    assign head_operand1 = a_mem[head];
    assign head_operand2 = b_mem[head];

    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                op_mem[tail] <= push_op;
                a_mem[tail]  <= push_operand1;
                b_mem[tail]  <= push_operand2;
                tail         <= tail + PTR_W'(1);
            end
            if (pop_ok) begin
                head <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/mdu_issue_controller.sv
// Queues MDU writes/starts in order and dispatches them when the MDU is idle; reads bypass the queue.
// Optional MDU_ISSUE_PERF_EN adds saturating read/full stall cycle counters.
module mdu_issue_controller
    import mdu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int OP_W  = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    input  logic [OP_W-1:0] req_op,
    input  logic [31:0]     req_operand1,
    input  logic [31:0]     req_operand2,
    output logic            stall,
    output logic [31:0]     read_data,
    output logic [OP_W-1:0] mdu_operation,
    output logic [31:0]     mdu_operand1,
    output logic [31:0]     mdu_operand2,
    output logic            mdu_start,
`ifdef MDU_ISSUE_PERF_EN
    output logic [31:0]     read_stall_cycles,
    output logic [31:0]     full_stall_cycles,
`endif
    input  logic            mdu_busy,
    input  logic [31:0]     mdu_data_read
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    issue_state_t     state_q, state_d;
    logic             guard_q, guard_d;
    logic             push, pop, dispatch;
    logic             full, empty, req_is_read;
    logic             read_blocked;
    logic [CNT_W-1:0] count, count_next;
    logic [OP_W-1:0]  head_op;
    word_t            head_operand1, head_operand2;

    mdu_cmd_fifo #(.DEPTH(DEPTH), .OP_W(OP_W)) u_fifo (
        .clock         (clock),
        .reset         (reset),
        .push          (push),
        .push_op       (req_op),
        .push_operand1 (req_operand1),
        .push_operand2 (req_operand2),
        .pop           (pop),
        .head_op       (head_op),
        .head_operand1 (head_operand1),
        .head_operand2 (head_operand2),
        .full          (full),
        .empty         (empty),
        .count         (count)
    );

    assign req_is_read  = is_read_op(req_op[2:0]);
    assign read_blocked = (count != '0) || mdu_busy || guard_q;
    // Live busy/guard are re-checked so a stale DISPATCH state can never double-start.
    assign dispatch     = (state_q == DISPATCH) && !empty && !mdu_busy && !guard_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            guard_q <= 1'b0;
        end else begin
            state_q <= state_d;
            guard_q <= guard_d;
        end
    end

    always_comb begin
        stall         = 1'b0;
        read_data     = '0;
        mdu_operation = OP_W'(READ_HI);
        mdu_operand1  = '0;
        mdu_operand2  = '0;
        mdu_start     = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        guard_d       = 1'b0;
        state_d       = state_q;

        if (dispatch) begin
            mdu_operation = head_op;
            mdu_operand1  = head_operand1;
            mdu_operand2  = head_operand2;
            mdu_start     = is_start_op(head_op[2:0]);
            pop           = 1'b1;
            guard_d       = is_start_op(head_op[2:0]);
        end

        // An unstalled read implies an empty queue, so it never collides with a dispatch.
        if (req_valid) begin
            if (req_is_read) begin
                stall = read_blocked;
                if (!read_blocked) begin
                    mdu_operation = req_op;
                    read_data     = mdu_data_read;
                end
            end else begin
                stall = full;
                push  = !full;
            end
        end

        count_next = count + CNT_W'(push) - CNT_W'(pop);
        if (count_next == '0) begin
            state_d = IDLE;
        end else if (mdu_busy || guard_d) begin
            state_d = PENDING;
        end else begin
            state_d = DISPATCH;
        end
    end

`ifdef MDU_ISSUE_PERF_EN
    logic read_stall_now, full_stall_now;

    assign read_stall_now = req_valid && req_is_read && read_blocked;
    assign full_stall_now = req_valid && !req_is_read && full;

    always_ff @(posedge clock) begin
        if (reset) begin
            read_stall_cycles <= '0;
            full_stall_cycles <= '0;
        end else begin
            if (read_stall_now && (read_stall_cycles != '1)) begin
                read_stall_cycles <= read_stall_cycles + 32'd1;
            end
            if (full_stall_now && (full_stall_cycles != '1)) begin
                full_stall_cycles <= full_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mdu_issue_controller.sv
// Directed bench for mdu_issue_controller with a behavioural multi-cycle MDU attached.
module tb_mdu_issue_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_operand1, req_operand2;
    logic        stall;
    logic [31:0] read_data;
    logic [2:0]  mdu_operation;
    logic [31:0] mdu_operand1, mdu_operand2;
    logic        mdu_start;
    logic        mdu_busy;
    logic [31:0] mdu_data_read;
`ifdef MDU_ISSUE_PERF_EN
    logic [31:0] read_stall_cycles, full_stall_cycles;
`endif

    int checks = 0;
    int errors = 0;
    int overlap_errs = 0;
    int idle_read_errs = 0;

    always #5 clock = ~clock;

    mdu_issue_controller #(.DEPTH(2), .OP_W(3)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_op        (req_op),
        .req_operand1  (req_operand1),
        .req_operand2  (req_operand2),
        .stall         (stall),
        .read_data     (read_data),
        .mdu_operation (mdu_operation),
        .mdu_operand1  (mdu_operand1),
        .mdu_operand2  (mdu_operand2),
        .mdu_start     (mdu_start),
`ifdef MDU_ISSUE_PERF_EN
        .read_stall_cycles (read_stall_cycles),
        .full_stall_cycles (full_stall_cycles),
`endif
        .mdu_busy      (mdu_busy),
        .mdu_data_read (mdu_data_read)
    );

    // Behavioural MDU: 4 busy cycles per start, results land as busy falls.
    logic [31:0] hi, lo, lat_a, lat_b;
    logic [2:0]  lat_op;
    int          cnt;

    assign mdu_data_read = (mdu_operation == 3'd1) ? lo : hi;

    always @(posedge clock) begin
        if (reset) begin
            hi <= 0; lo <= 0; mdu_busy <= 0; cnt <= 0;
            lat_op <= 0; lat_a <= 0; lat_b <= 0;
        end else if (mdu_start) begin
            mdu_busy <= 1; cnt <= 4;
            lat_op <= mdu_operation; lat_a <= mdu_operand1; lat_b <= mdu_operand2;
        end else if (mdu_busy) begin
            if (cnt == 1) begin
                mdu_busy <= 0;
                case (lat_op)
                    3'd4: {hi, lo} <= 64'(longint'(signed'(lat_a)) * longint'(signed'(lat_b)));
                    3'd5: {hi, lo} <= {32'd0, lat_a} * {32'd0, lat_b};
                    3'd6: if (lat_b != 0) begin
                        lo <= 32'(signed'(lat_a) / signed'(lat_b));
                        hi <= 32'(signed'(lat_a) % signed'(lat_b));
                    end
                    3'd7: if (lat_b != 0) begin
                        lo <= lat_a / lat_b;
                        hi <= lat_a % lat_b;
                    end
                    default: ;
                endcase
            end else begin
                cnt <= cnt - 1;
            end
        end else if (mdu_operation == 3'd2) begin
            hi <= mdu_operand1;
        end else if (mdu_operation == 3'd3) begin
            lo <= mdu_operand1;
        end
    end

    logic prev_start = 1'b0;
    always @(posedge clock) begin
        if (!reset && mdu_start && (mdu_busy || prev_start)) overlap_errs++;
        prev_start <= reset ? 1'b0 : mdu_start;
    end

    always @(negedge clock) begin
        if (!reset && !req_valid && read_data !== 32'd0) idle_read_errs++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one request, holds it while stalled (bounded), returns wait count and read data.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int waited, output logic [31:0] data);
        req_valid = 1'b1; req_op = op; req_operand1 = a; req_operand2 = b;
        waited = 0; data = 'x;
        for (int i = 0; i < 200; i++) begin
            #3;
            if (!stall) begin
                data = read_data;
                break;
            end
            waited++;
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
        req_valid = 1'b0; req_op = 3'd0; req_operand1 = 0; req_operand2 = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        int w;
        logic [31:0] d;

        reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_operand1 = 0; req_operand2 = 0;
        repeat (2) @(posedge clock);
        #3;
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_start", 32'(mdu_start), 32'd0);
        check("reset_op", 32'(mdu_operation), 32'd0);
        check("reset_opnd1", mdu_operand1, 32'd0);
        check("reset_read_data", read_data, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        idle(1);

        issue(3'd4, 32'd3, 32'hFFFFFFFE, w, d);
        check("smul_accept_wait", 32'(w), 32'd0);
        issue(3'd1, 0, 0, w, d);
        check("smul_lo_stalled", 32'(w > 0), 32'd1);
        check("smul_lo", d, 32'hFFFFFFFA);
        issue(3'd0, 0, 0, w, d);
        check("smul_hi", d, 32'hFFFFFFFF);

        issue(3'd5, 32'd7, 32'd6, w, d);
        check("b2b_umul_wait", 32'(w), 32'd0);
        issue(3'd7, 32'd100, 32'd7, w, d);
        check("b2b_udiv_wait", 32'(w), 32'd0);
        issue(3'd1, 0, 0, w, d);
        check("b2b_lo", d, 32'd14);
        issue(3'd0, 0, 0, w, d);
        check("b2b_hi", d, 32'd2);

        issue(3'd5, 32'd1, 32'd1, w, d);
        issue(3'd2, 32'h11, 0, w, d);
        issue(3'd3, 32'h22, 0, w, d);
        issue(3'd5, 32'd6, 32'd7, w, d);
        check("full_stalled", 32'(w > 0), 32'd1);
        issue(3'd1, 0, 0, w, d);
        check("full_lo", d, 32'd42);
        issue(3'd0, 0, 0, w, d);
        check("full_hi", d, 32'd0);

        issue(3'd4, 32'd5, 32'd5, w, d);
        issue(3'd2, 32'hDEADBEEF, 0, w, d);
        issue(3'd0, 0, 0, w, d);
        check("order_hi", d, 32'hDEADBEEF);
        issue(3'd1, 0, 0, w, d);
        check("order_lo", d, 32'd25);

        issue(3'd3, 32'h1234, 0, w, d);
        issue(3'd7, 32'd9, 32'd0, w, d);
        issue(3'd1, 0, 0, w, d);
        check("divzero_lo", d, 32'h1234);

        issue(3'd6, 32'hFFFFFFF9, 32'd2, w, d);
        issue(3'd1, 0, 0, w, d);
        check("sdiv_lo", d, 32'hFFFFFFFD);
        issue(3'd0, 0, 0, w, d);
        check("sdiv_hi", d, 32'hFFFFFFFF);

        issue(3'd5, 32'd2, 32'd3, w, d);
        issue(3'd2, 32'h5, 0, w, d);
        issue(3'd3, 32'h6, 0, w, d);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        #3;
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_start", 32'(mdu_start), 32'd0);
        @(posedge clock); #1;
        issue(3'd0, 0, 0, w, d);
        check("midrst_read_wait", 32'(w), 32'd0);
        check("midrst_read_hi", d, 32'd0);

        idle(2);
        check("no_start_overlap", 32'(overlap_errs), 32'd0);
        check("idle_read_data_zero", 32'(idle_read_errs), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
